// File: rtl/sensor_link_pkg.sv
// sensor_link_pkg
// Shared constants, state encodings and small helpers for the host-side
// DHT11 UART link peer (sensor frame "S:TTHH\n", LED frame "L:xy\n").
// No ports: imported by sensor_link_peer and led_cmd_sender.
package sensor_link_pkg;

  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_L     = 8'h4C;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_NL    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  localparam int SENSOR_FRAME_LEN = 7;
  localparam int CMD_FRAME_LEN    = 5;

  localparam int unsigned STALE_CYCLES_DEFAULT = 300_000_000;

  typedef enum logic [2:0] {
    P_IDLE, P_COLON, P_T1, P_T0, P_H1, P_H0, P_NL
  } parser_state_e;

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_SEND, S_GAP
  } sender_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

  // Shift-and-add keeps the multiply out of a DSP block: 10*d = 8d + 2d.
  function automatic logic [7:0] times_ten(input logic [3:0] d);
    return ({4'b0, d} << 3) + ({4'b0, d} << 1);
  endfunction

  // LED command frame ROM: 'L', ':', '0'+led1, '0'+led2, '\n'.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx,
                                          input logic       led1,
                                          input logic       led2);
    logic [7:0] b;
    case (idx)
      3'd0:    b = ASCII_L;
      3'd1:    b = ASCII_COLON;
      3'd2:    b = ASCII_ZERO + {7'b0, led1};
      3'd3:    b = ASCII_ZERO + {7'b0, led2};
      default: b = ASCII_NL;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sensor_link_peer_sender.sv
// led_cmd_sender
// Walks the 5-byte LED command frame out through a byte-level UART
// transmitter, one byte per tx_send/tx_done handshake.
// Ports:
//   clk_100Mhz, rst_n (async, active-low)
//   cmd_req    in  pulse: start a frame (ignored while cmd_busy)
//   led_1_cmd, led_2_cmd in  LED states, sampled on an accepted cmd_req
//   tx_busy, tx_done     in  transmitter status
//   tx_data    out byte presented to the transmitter
//   tx_send    out level request, held until tx_done
//   cmd_busy   out frame queued or in flight
module led_cmd_sender
  import sensor_link_pkg::*;
(
  input  logic       clk_100Mhz,
  input  logic       rst_n,
  input  logic       cmd_req,
  input  logic       led_1_cmd,
  input  logic       led_2_cmd,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_send,
  output logic       cmd_busy
);

  sender_state_e state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          led1_q, led1_d, led2_q, led2_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_send_q, tx_send_d;
  logic          busy_q, busy_d;

  // tx_send is a plain flop so the async reset drops it immediately.
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      led1_q    <= 1'b0;
      led2_q    <= 1'b0;
      tx_data_q <= 8'h00;
      tx_send_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      led1_q    <= led1_d;
      led2_q    <= led2_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    led1_d    = led1_q;
    led2_d    = led2_q;
    tx_data_d = tx_data_q;
    tx_send_d = tx_send_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_req) begin
          led1_d  = led_1_cmd;
          led2_d  = led_2_cmd;
          busy_d  = 1'b1;
          idx_d   = 3'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_data_d = cmd_byte(idx_q, led1_q, led2_q);
        if (!tx_busy) begin
          tx_send_d = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_done) begin
          tx_send_d = 1'b0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (idx_q < 3'(CMD_FRAME_LEN - 1)) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_LOAD;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign cmd_busy = busy_q;

endmodule

// File: rtl/sensor_link_peer.sv
// sensor_link_peer
// Host-side peer for the DHT11 UART link. Parses "S:TTHH\n" from the UART
// receiver into binary temperature/humidity and sends "L:xy\n" LED command
// frames through the UART transmitter (led_cmd_sender).
// Optional feature macro: STALE_TIMEOUT_EN -- when defined, sensor_stale
// asserts after STALE_CYCLES cycles with no accepted frame; otherwise it is 0.
// Ports:
//   clk_100Mhz, rst_n (async, active-low)
//   rx_data/rx_done            byte stream from the receiver
//   tx_data/tx_send/tx_busy/tx_done  transmitter handshake
//   led_1_cmd/led_2_cmd/cmd_req/cmd_busy  LED command request
//   temperature/humidity       last accepted values, 0..99
//   frame_valid/frame_error    one-cycle status pulses
//   sensor_stale               no frame within STALE_CYCLES
module sensor_link_peer
  import sensor_link_pkg::*;
#(
  parameter int unsigned STALE_CYCLES = STALE_CYCLES_DEFAULT
) (
  input  logic       clk_100Mhz,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic       led_1_cmd,
  input  logic       led_2_cmd,
  input  logic       cmd_req,
  output logic       cmd_busy,
  output logic [7:0] temperature,
  output logic [7:0] humidity,
  output logic       frame_valid,
  output logic       frame_error,
  output logic       sensor_stale
);

  if (STALE_CYCLES == 0) begin : g_cfg_check
    $error("STALE_CYCLES must be non-zero");
  end

  parser_state_e pstate_q, pstate_d;
  logic [3:0]    t1_q, t1_d, t0_q, t0_d, h1_q, h1_d, h0_q, h0_d;
  logic [7:0]    temp_q, temp_d, hum_q, hum_d;
  logic          valid_q, valid_d, error_q, error_d;
  logic [3:0]    digit;

  // For '0'..'9' the low nibble already equals byte - 0x30.
  assign digit = rx_data[3:0];

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q <= P_IDLE;
      t1_q     <= 4'd0;
      t0_q     <= 4'd0;
      h1_q     <= 4'd0;
      h0_q     <= 4'd0;
      temp_q   <= 8'd0;
      hum_q    <= 8'd0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      t1_q     <= t1_d;
      t0_q     <= t0_d;
      h1_q     <= h1_d;
      h0_q     <= h0_d;
      temp_q   <= temp_d;
      hum_q    <= hum_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  // An 'S' outside IDLE aborts the current frame but is itself the start
  // of a new one, so the parser resynchronises straight into COLON.
  always_comb begin
    pstate_d = pstate_q;
    t1_d     = t1_q;
    t0_d     = t0_q;
    h1_d     = h1_q;
    h0_d     = h0_q;
    temp_d   = temp_q;
    hum_d    = hum_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    if (rx_done) begin
      if (pstate_q != P_IDLE && rx_data == ASCII_S) begin
        error_d  = 1'b1;
        pstate_d = P_COLON;
      end else begin
        case (pstate_q)
          P_IDLE: begin
            if (rx_data == ASCII_S) pstate_d = P_COLON;
          end
          P_COLON: begin
            if (rx_data == ASCII_COLON) begin
              pstate_d = P_T1;
            end else begin
              error_d  = 1'b1;
              pstate_d = P_IDLE;
            end
          end
          P_T1, P_T0, P_H1, P_H0: begin
            if (is_digit(rx_data)) begin
              case (pstate_q)
                P_T1:    begin t1_d = digit; pstate_d = P_T0; end
                P_T0:    begin t0_d = digit; pstate_d = P_H1; end
                P_H1:    begin h1_d = digit; pstate_d = P_H0; end
                default: begin h0_d = digit; pstate_d = P_NL; end
              endcase
            end else begin
              error_d  = 1'b1;
              pstate_d = P_IDLE;
            end
          end
          P_NL: begin
            if (rx_data == ASCII_NL) begin
              temp_d   = times_ten(t1_q) + {4'b0, t0_q};
              hum_d    = times_ten(h1_q) + {4'b0, h0_q};
              valid_d  = 1'b1;
            end else begin
              error_d  = 1'b1;
            end
            pstate_d = P_IDLE;
          end
          default: pstate_d = P_IDLE;
        endcase
      end
    end
  end

  assign temperature = temp_q;
  assign humidity    = hum_q;
  assign frame_valid = valid_q;
  assign frame_error = error_q;

`ifdef STALE_TIMEOUT_EN
  logic [31:0] stale_cnt_q;

  // Clearing on the frame_valid pulse means sensor_stale drops the cycle
  // after it; the counter saturates so stale stays high indefinitely.
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      stale_cnt_q <= 32'd0;
    end else if (valid_q) begin
      stale_cnt_q <= 32'd0;
    end else if (stale_cnt_q != STALE_CYCLES) begin
      stale_cnt_q <= stale_cnt_q + 32'd1;
    end
  end

  assign sensor_stale = (stale_cnt_q == STALE_CYCLES);
`else
  assign sensor_stale = 1'b0;
`endif

  led_cmd_sender u_sender (
    .clk_100Mhz (clk_100Mhz),
    .rst_n      (rst_n),
    .cmd_req    (cmd_req),
    .led_1_cmd  (led_1_cmd),
    .led_2_cmd  (led_2_cmd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .cmd_busy   (cmd_busy)
  );

endmodule

// File: doc/sensor_link_peer.md
Name: sensor_link_peer

Overview:
- Host-side peer for the DHT11 UART link. Parses the sensor frame "S:TTHH\n" (7 ASCII bytes) from a byte-level UART receiver into binary temperature and humidity.
- Builds and sends the LED command frame "L:xy\n" (5 bytes) through a byte-level UART transmitter.
- Sits between the team's RxUnit/TxUnit instances (9600 baud, odd parity) and the display/control logic on the host FPGA.

Parameters:
- STALE_CYCLES, 300_000_000: cycles without a valid frame before sensor_stale asserts (3 s at 100 MHz); used only with STALE_TIMEOUT_EN.

Ports:
- clk_100Mhz  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- rx_data  input  8  byte from the UART receiver
- rx_done  input  1  one-cycle pulse; rx_data is valid this cycle
- tx_data  output  8  byte to the UART transmitter
- tx_send  output  1  level request to the UART transmitter
- tx_busy  input  1  transmitter active
- tx_done  input  1  one-cycle pulse at end of a byte
- led_1_cmd  input  1  requested state of remote LED 1
- led_2_cmd  input  1  requested state of remote LED 2
- cmd_req  input  1  one-cycle pulse: send an LED command frame
- cmd_busy  output  1  LED frame is queued or being sent
- temperature  output  8  last valid temperature, binary 0..99
- humidity  output  8  last valid humidity, binary 0..99
- frame_valid  output  1  one-cycle pulse when a complete frame is accepted
- frame_error  output  1  one-cycle pulse on a malformed frame
- sensor_stale  output  1  no valid frame within STALE_CYCLES (tied 0 without the feature)

Behaviour:
- Reset values: all outputs 0, including tx_data, tx_send, cmd_busy, temperature and humidity. Both state machines go to IDLE; any partial frame is discarded.
- Parser states: IDLE, COLON, T1, T0, H1, H0, NL. State advances only on rx_done.
  - IDLE: 'S' (0x53) -> COLON. Any other byte is ignored silently.
  - COLON: ':' (0x3A) -> T1. Otherwise error.
  - T1, T0, H1, H0: byte in 0x30..0x39 -> latch digit and go to next state. Otherwise error.
  - NL: 0x0A -> accept. Otherwise error.
- Resync: 'S' received in any non-IDLE state -> frame_error pulse, then go to COLON (the 'S' starts a new frame).
- Error: frame_error pulses for 1 cycle, state -> IDLE, temperature and humidity are unchanged.
- Accept: on the cycle after the NL byte's rx_done, temperature <= T1*10+T0 and humidity <= H1*10+H0, both registered together in the same cycle; frame_valid pulses in that same cycle.
- Arithmetic: digits are 4-bit (byte - 0x30). Multiply by 10 as (d<<3)+(d<<1). Result is 8-bit, maximum 99, no overflow.
- Sender states: IDLE, LOAD, SEND, GAP.
  - cmd_req in IDLE: latch led_1_cmd and led_2_cmd, set cmd_busy=1, index=0, go to LOAD.
  - cmd_req while cmd_busy=1: ignored, not queued.
  - LOAD: tx_data <= byte[index]. Bytes are 'L', ':', '0'+led1, '0'+led2, '\n'. If tx_busy=0 -> SEND.
  - SEND: tx_send=1 and tx_data held stable until tx_done.
  - On tx_done: tx_send <= 0, go to GAP (tx_send low for at least 1 cycle).
  - GAP: index<4 -> index+1, go to LOAD. index==4 -> cmd_busy=0, go to IDLE.
- Parser and sender run independently; simultaneous rx_done and tx_done are both handled in the same cycle.
- Reset mid-operation: both machines return to IDLE immediately and tx_send drops asynchronously.

Optional Feature:
- Macro: STALE_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on frame_valid and otherwise increments, saturating at STALE_CYCLES.
  - sensor_stale=1 while counter == STALE_CYCLES; it clears in the cycle after frame_valid.
  - After reset the counter starts at 0, so sensor_stale rises STALE_CYCLES cycles after reset if no frame arrives.
- Not defined: no counter is built; sensor_stale is tied to 0.

Decomposition:
- Package sensor_link_pkg holds:
  - ASCII constants: S, L, colon, newline, '0', '9'.
  - Frame lengths: 7 and 5.
  - Parser and sender state enums.
  - STALE_CYCLES default.
- One sub-module, led_cmd_sender: the sender state machine and byte ROM. The parser stays in the top level.

Test Plan:
- Bytes "S:2345\n" with rx_done pulses -> temperature=23, humidity=45; exactly one frame_valid pulse, one cycle after the '\n' byte; no frame_error.
- "S:2X45\n" after a valid 23/45 frame -> one frame_error pulse on the 'X'; outputs stay 23/45; no frame_valid.
- "S:1S:9988\n" -> one frame_error at the second 'S', then temperature=99, humidity=88 with one frame_valid.
- cmd_req with led_1_cmd=0, led_2_cmd=1, transmitter model with tx_done after 20 cycles -> bytes 0x4C 0x3A 0x30 0x31 0x0A in order; tx_send low at least 1 cycle between bytes; a second cmd_req mid-frame is ignored; cmd_busy clears after the last tx_done.
- rst_n asserted during byte 3 of the LED frame and during parser state H1 -> tx_send=0 and all outputs 0 immediately; a following complete frame "S:0102\n" parses to 1/2.
- With STALE_TIMEOUT_EN and STALE_CYCLES=1000: no frames -> sensor_stale=1 at cycle 1000; a valid frame -> sensor_stale=0 the next cycle. Without the macro, sensor_stale stays 0.
